// File: rtl/hyper_rd_streamer.sv
// hyper_rd_streamer: buffers 32-bit read words from hyper_xface in a small
// FIFO and streams them out byte by byte through the uart_tx handshake.
// Optional feature macro: HYPER_RD_STREAMER_TRAILER_EN appends one XOR
// checksum byte after every burst (a burst ends when a word completes and
// the FIFO is empty).
module hyper_rd_streamer #(
    parameter int DEPTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              rd_d,
    input  logic                     rd_rdy,
    input  logic                     tx_ready,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_LOW,
        WAIT_HIGH
`ifdef HYPER_RD_STREAMER_TRAILER_EN
        ,
        TRAILER
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     sh_q, sh_d;
    logic [1:0]      idx_q, idx_d;
    logic            tx_start_q, tx_start_d;
    logic            ovf_q, ovf_d;
    logic [31:0]     mem_q [DEPTH];
`ifdef HYPER_RD_STREAMER_TRAILER_EN
    logic [7:0]      acc_q, acc_d;
    logic            trl_q, trl_d;
`endif

    logic            full, empty, push, pop;
    logic [7:0]      cur_byte;
    logic [31:0]     sh_shift;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign cur_byte = MSB_FIRST ? sh_q[31:24] : sh_q[7:0];
    assign sh_shift = MSB_FIRST ? {sh_q[23:0], 8'h00} : {8'h00, sh_q[31:8]};

    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    // the incoming word; the head is read before the write lands.
    assign push = rd_rdy && (!full || pop);

    // FSM next state, pop decision and byte sequencing
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        idx_d      = idx_q;
        tx_start_d = 1'b0;
        pop        = 1'b0;
`ifdef HYPER_RD_STREAMER_TRAILER_EN
        acc_d      = acc_q;
        trl_d      = trl_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty && tx_ready) begin
                    pop     = 1'b1;
                    sh_d    = mem_q[rd_ptr_q];
                    idx_d   = 2'd0;
                    state_d = START;
                end
            end
            START: begin
                // Never strobe the uart while it reports itself busy.
                if (tx_ready) begin
                    tx_start_d = 1'b1;
                    state_d    = WAIT_LOW;
`ifdef HYPER_RD_STREAMER_TRAILER_EN
                    if (!trl_q) acc_d = acc_q ^ cur_byte;
`endif
                end
            end
            WAIT_LOW: begin
                if (!tx_ready) state_d = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (tx_ready) begin
`ifdef HYPER_RD_STREAMER_TRAILER_EN
                    if (trl_q) begin
                        trl_d   = 1'b0;
                        state_d = IDLE;
                    end else if (idx_q != 2'd3) begin
                        sh_d    = sh_shift;
                        idx_d   = idx_q + 2'd1;
                        state_d = START;
                    end else if (empty) begin
                        state_d = TRAILER;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    if (idx_q != 2'd3) begin
                        sh_d    = sh_shift;
                        idx_d   = idx_q + 2'd1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef HYPER_RD_STREAMER_TRAILER_EN
            TRAILER: begin
                // Checksum goes in the leading byte lane; accumulator restarts.
                sh_d    = MSB_FIRST ? {acc_q, 24'h0} : {24'h0, acc_q};
                acc_d   = 8'h00;
                trl_d   = 1'b1;
                state_d = START;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointer, occupancy and sticky overflow bookkeeping
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | (rd_rdy && full && !pop);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sh_q       <= '0;
            idx_q      <= '0;
            tx_start_q <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef HYPER_RD_STREAMER_TRAILER_EN
            acc_q      <= '0;
            trl_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sh_q       <= sh_d;
            idx_q      <= idx_d;
            tx_start_q <= tx_start_d;
            ovf_q      <= ovf_d;
`ifdef HYPER_RD_STREAMER_TRAILER_EN
            acc_q      <= acc_d;
            trl_q      <= trl_d;
`endif
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wr_ptr_q] <= rd_d;
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = cur_byte;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign busy       = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_hyper_rd_streamer.sv
// Directed bench for hyper_rd_streamer: two instances (MSB_FIRST=1 and 0),
// each driven by a small uart_tx model that drops ready 2 clocks after start.
module tb_hyper_rd_streamer;

`ifdef HYPER_RD_STREAMER_TRAILER_EN
    localparam int TRL = 1;
`else
    localparam int TRL = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rd_d0 = '0, rd_d1 = '0;
    logic        rd_rdy0 = 1'b0, rd_rdy1 = 1'b0;
    logic [1:0]  tx_st, tx_rdy, bsy, ovf;
    logic [1:0]  tx_rdy_m = 2'b11;
    logic [1:0]  hold = 2'b00;
    logic [7:0]  tx_dat0, tx_dat1;
    logic [4:0]  fc0, fc1;
    int          ucnt [2];
    int          viol = 0;
    logic [7:0]  q0 [$];
    logic [7:0]  q1 [$];
    int          total = 0, bad = 0;

    assign tx_rdy = tx_rdy_m & ~hold;

    always #5 clk = ~clk;

    hyper_rd_streamer #(.DEPTH(16), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .reset(reset), .rd_d(rd_d0), .rd_rdy(rd_rdy0),
        .tx_ready(tx_rdy[0]), .tx_start(tx_st[0]), .tx_data(tx_dat0),
        .fifo_count(fc0), .overflow(ovf[0]), .busy(bsy[0]));

    hyper_rd_streamer #(.DEPTH(16), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .reset(reset), .rd_d(rd_d1), .rd_rdy(rd_rdy1),
        .tx_ready(tx_rdy[1]), .tx_start(tx_st[1]), .tx_data(tx_dat1),
        .fifo_count(fc1), .overflow(ovf[1]), .busy(bsy[1]));

    // uart_tx model plus byte capture
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                tx_rdy_m[i] <= 1'b1;
                ucnt[i]     <= 0;
            end else if (tx_st[i]) begin
                if (!tx_rdy[i]) viol <= viol + 1;
                ucnt[i] <= 1;
            end else if (ucnt[i] == 8) begin
                ucnt[i]     <= 0;
                tx_rdy_m[i] <= 1'b1;
            end else if (ucnt[i] != 0) begin
                ucnt[i] <= ucnt[i] + 1;
                if (ucnt[i] == 1) tx_rdy_m[i] <= 1'b0;
            end
        end
        if (!reset && tx_st[0]) q0.push_back(tx_dat0);
        if (!reset && tx_st[1]) q1.push_back(tx_dat1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic push0(input logic [31:0] d);
        @(negedge clk);
        rd_d0   = d;
        rd_rdy0 = 1'b1;
    endtask

    task automatic drop0();
        @(negedge clk);
        rd_rdy0 = 1'b0;
    endtask

    task automatic wait_done(input int i, input int max);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(ucnt[i] == 0 && tx_rdy_m[i] && !bsy[i]) && n < max);
        if (n >= max) chk("timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    function automatic logic [31:0] word0(input int w);
        return {q0[4*w], q0[4*w+1], q0[4*w+2], q0[4*w+3]};
    endfunction

    initial begin
        int lat;
        int n;
        logic [31:0] exp_b [12];

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_start", {31'd0, tx_st[0]}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_dat0}, 32'd0);
        chk("rst_count", {27'd0, fc0}, 32'd0);
        chk("rst_ovf", {31'd0, ovf[0]}, 32'd0);
        chk("rst_busy", {31'd0, bsy[0]}, 32'd0);
        reset = 1'b0;
        q0.delete();
        q1.delete();

        // single word, latency
        @(negedge clk);
        rd_d0 = 32'h12345678; rd_rdy0 = 1'b1;
        @(posedge clk); #1 rd_rdy0 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (tx_st[0]) begin lat = k; break; end
        end
        chk("latency", lat, 2);
        wait_done(0, 500);
        chk("single_n", q0.size(), 4 + TRL);
        chk("single_w", word0(0), 32'h12345678);
        chk("single_busy", {31'd0, bsy[0]}, 32'd0);

        // burst of three, held back so occupancy builds up
        do_reset();
        hold[0] = 1'b1;
        push0(32'hA0A1A2A3); push0(32'hB0B1B2B3); push0(32'hC0C1C2C3); drop0();
        chk("burst_peak", {27'd0, fc0}, 32'd3);
        hold[0] = 1'b0;
        wait_done(0, 1000);
        exp_b = '{8'hA0,8'hA1,8'hA2,8'hA3,8'hB0,8'hB1,8'hB2,8'hB3,8'hC0,8'hC1,8'hC2,8'hC3};
        chk("burst_n", q0.size(), 12 + TRL);
        for (int k = 0; k < 12; k++)
            if (k < q0.size()) chk($sformatf("burst_b%0d", k), {24'd0, q0[k]}, exp_b[k]);
        if (TRL == 1 && q0.size() > 12) chk("burst_trl", {24'd0, q0[12]}, 32'h00);
        chk("burst_ovf", {31'd0, ovf[0]}, 32'd0);

        // overflow: 17 pushes into a 16-deep FIFO
        do_reset();
        hold[0] = 1'b1;
        for (int k = 0; k <= 16; k++) push0(k);
        drop0();
        chk("ovf_count", {27'd0, fc0}, 32'd16);
        chk("ovf_flag", {31'd0, ovf[0]}, 32'd1);
        hold[0] = 1'b0;
        wait_done(0, 3000);
        chk("ovf_n", q0.size(), 64 + TRL);
        if (q0.size() >= 64)
            for (int w = 0; w < 16; w++) chk($sformatf("ovf_w%0d", w), word0(w), w);

        // full FIFO with a push coincident with an IDLE pop
        do_reset();
        hold[0] = 1'b1;
        for (int k = 0; k < 16; k++) push0(32'h100 + k);
        drop0();
        chk("fp_full", {27'd0, fc0}, 32'd16);
        @(negedge clk);
        hold[0] = 1'b0; rd_d0 = 32'h55; rd_rdy0 = 1'b1;
        @(posedge clk); #1 rd_rdy0 = 1'b0;
        chk("fp_count", {27'd0, fc0}, 32'd16);
        chk("fp_ovf", {31'd0, ovf[0]}, 32'd0);
        wait_done(0, 3000);
        chk("fp_n", q0.size(), 68 + TRL);
        if (q0.size() >= 68) begin
            chk("fp_first", word0(0), 32'h100);
            chk("fp_last", word0(16), 32'h55);
        end

        // reset during the second byte
        do_reset();
        push0(32'hDEADBEEF); drop0();
        n = 0;
        while (q0.size() < 2 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) chk("mid_timeout", 32'd1, 32'd0);
        @(negedge clk);
        reset = 1'b1; rd_d0 = 32'hFFFF0000; rd_rdy0 = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; rd_rdy0 = 1'b0;
        #1;
        chk("mid_count", {27'd0, fc0}, 32'd0);
        chk("mid_busy", {31'd0, bsy[0]}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("mid_nomore", q0.size(), 2);
        if (q0.size() >= 2) chk("mid_b01", {16'd0, q0[0], q0[1]}, 32'hDEAD);
        q0.delete();
        push0(32'h00000001); drop0();
        wait_done(0, 500);
        chk("after_n", q0.size(), 4 + TRL);
        if (q0.size() >= 4) chk("after_w", word0(0), 32'h00000001);

        // LSB-first instance
        @(negedge clk);
        rd_d1 = 32'h11223344; rd_rdy1 = 1'b1;
        @(negedge clk);
        rd_rdy1 = 1'b0;
        wait_done(1, 500);
        chk("lsb_n", q1.size(), 4 + TRL);
        if (q1.size() >= 4) chk("lsb_w", {q1[0], q1[1], q1[2], q1[3]}, 32'h44332211);
        chk("lsb_ovf", {31'd0, ovf[1]}, 32'd0);
        chk("lsb_count", {27'd0, fc1}, 32'd0);

        chk("start_vs_ready", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
